// File: rtl/hazard_if.sv
// hazard_if: stage register fields and control bits into the hazard controller, stall/forward/MD status back out.
interface hazard_if;
  logic [4:0]  rsD, rtD, rsE, rtE;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW;
  logic        MemtoRegE, MemtoRegM;
  logic        BranchD, MdUseD, MdStartE, MdIsDivE, CntClr;
  logic        StallF, StallD, FlushE;
  logic        ForwardAD, ForwardBD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        MdBusy;
  logic [31:0] StallCnt;
  modport master (
    output rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MdUseD, MdStartE, MdIsDivE, CntClr,
    input  StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           MdBusy, StallCnt
  );
  modport slave (
    input  rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MdUseD, MdStartE, MdIsDivE, CntClr,
    output StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           MdBusy, StallCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: MIPS 5-stage stall/flush/forward control plus mult/div busy FSM.
// Define HAZ_STALLCNT_EN to enable the StallCnt stall-cycle counter; otherwise StallCnt is 0.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave h
);
  localparam logic [0:0] IDLE = 1'b0, BUSY = 1'b1;
  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1), DIV_LAST = 6'(DIV_CYCLES - 1);
  logic [0:0] state;
  logic [5:0] cnt;
  logic       lwstall, branchstall, mdstall, stall;
  // r0 is hardwired zero, so a write to it never creates a dependency
  function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && dst != 5'd0 && dst == src;
  endfunction
  assign h.ForwardAE = hit(h.RegWriteM, h.WriteRegM, h.rsE) ? 2'b10 :
                       hit(h.RegWriteW, h.WriteRegW, h.rsE) ? 2'b01 : 2'b00;
  assign h.ForwardBE = hit(h.RegWriteM, h.WriteRegM, h.rtE) ? 2'b10 :
                       hit(h.RegWriteW, h.WriteRegW, h.rtE) ? 2'b01 : 2'b00;
  assign h.ForwardAD = hit(h.RegWriteM, h.WriteRegM, h.rsD);
  assign h.ForwardBD = hit(h.RegWriteM, h.WriteRegM, h.rtD);
  assign lwstall = h.MemtoRegE && (hit(h.RegWriteE, h.WriteRegE, h.rsD) || hit(h.RegWriteE, h.WriteRegE, h.rtD));
  assign branchstall = h.BranchD && (hit(h.RegWriteE, h.WriteRegE, h.rsD) || hit(h.RegWriteE, h.WriteRegE, h.rtD) ||
                                     hit(h.MemtoRegM, h.WriteRegM, h.rsD) || hit(h.MemtoRegM, h.WriteRegM, h.rtD));
  assign mdstall = h.MdUseD && h.MdBusy;
  assign stall = lwstall | branchstall | mdstall;
  assign h.StallF = stall;
  assign h.StallD = stall;
  assign h.FlushE = stall;
  assign h.MdBusy = state == BUSY;
  // cnt holds the remaining busy cycles minus one, so BUSY lasts exactly N cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else if (state == IDLE) begin
      if (h.MdStartE) begin
        state <= BUSY;
        cnt   <= h.MdIsDivE ? DIV_LAST : MUL_LAST;
      end
    end else if (cnt != 6'd0) begin
      cnt <= cnt - 6'd1;
    end else begin
      state <= IDLE;
    end
  end
`ifdef HAZ_STALLCNT_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk) begin
    if (rst || h.CntClr) stall_cnt <= 32'd0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end
  assign h.StallCnt = stall_cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = h.CntClr;
  assign h.StallCnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors push expected outputs into a queue; a negedge monitor pops and compares.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  hazard_if h ();
  hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (.clk(clk), .rst(rst), .h(h));
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        st;
    logic [1:0]  fae, fbe;
    logic        fad, fbd, busy;
    logic [31:0] cnt;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  logic [31:0] cnt_model = 32'd0;

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s actual=%0h expected=%0h", n, f, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "StallF", 32'(h.StallF), 32'(e.st));
      chk(e.name, "StallD", 32'(h.StallD), 32'(e.st));
      chk(e.name, "FlushE", 32'(h.FlushE), 32'(e.st));
      chk(e.name, "ForwardAE", 32'(h.ForwardAE), 32'(e.fae));
      chk(e.name, "ForwardBE", 32'(h.ForwardBE), 32'(e.fbe));
      chk(e.name, "ForwardAD", 32'(h.ForwardAD), 32'(e.fad));
      chk(e.name, "ForwardBD", 32'(h.ForwardBD), 32'(e.fbd));
      chk(e.name, "MdBusy", 32'(h.MdBusy), 32'(e.busy));
      chk(e.name, "StallCnt", h.StallCnt, e.cnt);
    end
  end

  task automatic clear();
    h.rsD = 0; h.rtD = 0; h.rsE = 0; h.rtE = 0;
    h.WriteRegE = 0; h.WriteRegM = 0; h.WriteRegW = 0;
    h.RegWriteE = 0; h.RegWriteM = 0; h.RegWriteW = 0;
    h.MemtoRegE = 0; h.MemtoRegM = 0; h.BranchD = 0;
    h.MdUseD = 0; h.MdStartE = 0; h.MdIsDivE = 0; h.CntClr = 0;
  endtask

  task automatic vec(input string n, input logic st, input logic [1:0] fae, input logic [1:0] fbe,
                     input logic fad, input logic fbd, input logic busy);
    exp_t e;
    e.name = n; e.st = st; e.fae = fae; e.fbe = fbe; e.fad = fad; e.fbd = fbd; e.busy = busy;
    e.cnt = cnt_model;
    q.push_back(e);
`ifdef HAZ_STALLCNT_EN
    cnt_model = (rst || h.CntClr) ? 32'd0 : st ? cnt_model + 32'd1 : cnt_model;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clear();
    @(posedge clk);
    #1;
    vec("reset0", 0, 2'b00, 2'b00, 0, 0, 0);
    vec("reset1", 0, 2'b00, 2'b00, 0, 0, 0);
    rst = 1'b0;
    h.RegWriteM = 1; h.WriteRegM = 5; h.RegWriteW = 1; h.WriteRegW = 5; h.rsE = 5;
    vec("fwd_m_prio", 0, 2'b10, 2'b00, 0, 0, 0);
    h.RegWriteM = 0;
    vec("fwd_w", 0, 2'b01, 2'b00, 0, 0, 0);
    h.WriteRegW = 0; h.rsE = 0;
    vec("fwd_r0", 0, 2'b00, 2'b00, 0, 0, 0);
    clear();
    h.RegWriteM = 1; h.WriteRegM = 7; h.rtE = 7; h.rsD = 7; h.rtD = 7;
    vec("fwd_b_d", 0, 2'b00, 2'b10, 1, 1, 0);
    clear();
    h.MemtoRegE = 1; h.RegWriteE = 1; h.WriteRegE = 8; h.rtD = 8;
    vec("lw_use", 1, 2'b00, 2'b00, 0, 0, 0);
    clear();
    h.rtD = 8;
    vec("lw_bubble", 0, 2'b00, 2'b00, 0, 0, 0);
    h.MemtoRegE = 1; h.RegWriteE = 1; h.WriteRegE = 0; h.rtD = 0;
    vec("lw_r0", 0, 2'b00, 2'b00, 0, 0, 0);
    clear();
    h.BranchD = 1; h.rsD = 3; h.RegWriteE = 1; h.WriteRegE = 3;
    vec("br_alu_e", 1, 2'b00, 2'b00, 0, 0, 0);
    h.RegWriteE = 0; h.WriteRegE = 0; h.MemtoRegM = 1; h.RegWriteM = 1; h.WriteRegM = 3;
    vec("br_load_m", 1, 2'b00, 2'b00, 1, 0, 0);
    h.MemtoRegM = 0;
    vec("br_fwd_m", 0, 2'b00, 2'b00, 1, 0, 0);
    clear();
    h.BranchD = 1; h.rsD = 4; h.RegWriteE = 1; h.MemtoRegE = 1; h.WriteRegE = 4;
    vec("br_and_lw", 1, 2'b00, 2'b00, 0, 0, 0);
    clear();
    h.MdStartE = 1;
    vec("mul_start", 0, 2'b00, 2'b00, 0, 0, 0);
    h.MdStartE = 0; h.MdUseD = 1;
    for (int i = 0; i < 4; i++) vec("mul_busy", 1, 2'b00, 2'b00, 0, 0, 1);
    vec("mul_release", 0, 2'b00, 2'b00, 0, 0, 0);
    clear();
    h.MdStartE = 1; h.MdIsDivE = 1;
    vec("div_start", 0, 2'b00, 2'b00, 0, 0, 0);
    h.MdStartE = 0; h.MdIsDivE = 0; h.MdUseD = 1;
    for (int i = 0; i < 32; i++) vec("div_busy", 1, 2'b00, 2'b00, 0, 0, 1);
    vec("div_release", 0, 2'b00, 2'b00, 0, 0, 0);
    clear();
    h.MdStartE = 1; h.MdIsDivE = 1;
    vec("div2_start", 0, 2'b00, 2'b00, 0, 0, 0);
    h.MdStartE = 0; h.MdIsDivE = 0; h.MdUseD = 1;
    for (int i = 0; i < 9; i++) vec("div2_busy", 1, 2'b00, 2'b00, 0, 0, 1);
    rst = 1'b1;
    vec("div2_rst_cycle", 1, 2'b00, 2'b00, 0, 0, 1);
    rst = 1'b0;
    vec("div2_after_rst", 0, 2'b00, 2'b00, 0, 0, 0);
    clear();
    h.MemtoRegE = 1; h.RegWriteE = 1; h.WriteRegE = 9; h.rsD = 9;
    vec("cnt_stall", 1, 2'b00, 2'b00, 0, 0, 0);
    h.CntClr = 1;
    vec("cnt_clr_stall", 1, 2'b00, 2'b00, 0, 0, 0);
    h.CntClr = 0;
    vec("cnt_after_clr", 1, 2'b00, 2'b00, 0, 0, 0);
    clear();
    vec("cnt_idle", 0, 2'b00, 2'b00, 0, 0, 0);
`ifdef HAZ_STALLCNT_EN
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    cnt_model = 32'hFFFF_FFFF;
    h.MemtoRegE = 1; h.RegWriteE = 1; h.WriteRegE = 9; h.rsD = 9;
    vec("wrap0", 1, 2'b00, 2'b00, 0, 0, 0);
    vec("wrap1", 1, 2'b00, 2'b00, 0, 0, 0);
    clear();
    vec("wrap_done", 0, 2'b00, 2'b00, 0, 0, 0);
`endif
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
